// File: rtl/msg_coeff_serializer.sv
`default_nettype none
// ============================================================================
// Module  : msg_coeff_serializer
// Brief   : Decompresses N-bit message words into coefficients mod Q, one per
//           cycle LSB first, behind a one-word skid buffer.
// Revision: 1.0 - initial release
// ============================================================================
module msg_coeff_serializer #(
   parameter int Q      = 17,
   parameter int N      = 4,
   parameter int COEF_W = 5,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N-1:0]          in_bits,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [COEF_W-1:0]     out_coeff,
   output logic [$clog2(N)-1:0]  out_idx,
   output logic                  out_last,
   output logic [CNT_W-1:0]      frame_cnt
);

   localparam int                IDX_W       = $clog2(N);
   localparam logic [COEF_W-1:0] c_ONE_COEFF = COEF_W'((Q + 1) / 2);
   localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(N - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [N-1:0]       sr_q, sr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N-1:0]       buf_q, buf_d;
   logic               buf_full_q, buf_full_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               w_in_fire;
   logic               w_out_fire;
   logic               w_last_fire;

   // in_ready comes only from registered state so out_ready never reaches it.
   assign in_ready    = ~buf_full_q;
   assign out_valid   = (state_q == S_EMIT);
   assign out_idx     = idx_q;
   assign out_last    = out_valid & (idx_q == c_LAST_IDX);
   assign out_coeff   = (out_valid && sr_q[idx_q]) ? c_ONE_COEFF : '0;
   assign frame_cnt   = cnt_q;

   assign w_in_fire   = in_valid & in_ready;
   assign w_out_fire  = out_valid & out_ready;
   assign w_last_fire = w_out_fire & out_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         sr_q       <= '0;
         idx_q      <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         idx_q      <= idx_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sr_d       = sr_q;
      idx_d      = idx_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      cnt_d      = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (w_in_fire) begin
               sr_d    = in_bits;
               idx_d   = '0;
               state_d = S_EMIT;
            end
         end

         S_EMIT: begin
            if (w_last_fire) begin
               cnt_d = cnt_q + CNT_W'(1);
               idx_d = '0;
               // A buffered word always wins; in_ready is low then anyway.
               if (buf_full_q) begin
                  sr_d       = buf_q;
                  buf_full_d = 1'b0;
               end else if (w_in_fire) begin
                  sr_d = in_bits;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               if (w_out_fire) begin
                  idx_d = idx_q + IDX_W'(1);
               end
               if (w_in_fire) begin
                  buf_d      = in_bits;
                  buf_full_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: doc/msg_coeff_serializer.md
# msg_coeff_serializer

Downstream of the message-bit unpacker in the Baby Kyber encryption path. Accepts N-bit message words over a valid/ready handshake and decompresses each bit to a polynomial coefficient mod Q: bit 0 becomes 0, and bit 1 becomes ceil(Q/2). It emits the coefficients one per cycle, LSB first, with index and last flags, to the polynomial adder. A one-word skid buffer allows the next word to be accepted while the current word is streaming, so a steady stream runs with no bubbles.

## Interface
- Q, 17: modulus; the decompressed "1" value is (Q+1)/2 = 9.
- N, 4: coefficients per word; also the message bits per word.
- COEF_W, 5: coefficient width; must satisfy 2^COEF_W > Q-1.
- CNT_W, 8: width of the completed-word counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_bits is valid.
- in_ready  out  1  the block can accept a word; equals !buf_full.
- in_bits  in  N  message bits; bit i maps to coefficient i.
- out_valid  out  1  out_coeff/out_idx/out_last are valid.
- out_ready  in  1  the consumer accepts the current coefficient.
- out_coeff  out  COEF_W  decompressed coefficient, 0 or (Q+1)/2.
- out_idx  out  $clog2(N)  coefficient index within the word.
- out_last  out  1  out_idx == N-1 while out_valid is high.
- frame_cnt  out  CNT_W  count of fully emitted words; wraps modulo 2^CNT_W.

## Operation
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - last_fire = out_fire & out_last.
- Registered state:
  - state: IDLE or EMIT.
  - sr[N-1:0]: the active word.
  - idx: the current index.
  - buf[N-1:0] and buf_full: the skid buffer.
  - frame_cnt.
- out_valid = (state == EMIT).
- out_coeff = sr[idx] ? (Q+1)/2 : 0 when out_valid is high; otherwise 0.
- out_idx = idx.
- out_last = out_valid & (idx == N-1).
- IDLE:
  - in_fire: sr <= in_bits, idx <= 0, go to EMIT.
  - buf_full is always 0 in IDLE.
- EMIT, out_fire and not last: idx <= idx+1.
- EMIT, in_fire without last_fire: buf <= in_bits, buf_full <= 1.
- EMIT, last_fire: frame_cnt <= frame_cnt+1, idx <= 0, then one of:
  - buf_full: sr <= buf, buf_full <= 0, stay in EMIT.
  - else if in_fire in the same cycle: sr <= in_bits directly (buf stays empty), stay in EMIT.
  - else go to IDLE.
- No out_fire: sr, idx and the outputs hold stable. The output is never withdrawn or changed while out_valid=1 and out_ready=0.
- in_ready depends only on registered state, with no combinational path from out_ready. The block therefore holds at most 2 words (sr + buf).
- Arithmetic:
  - idx wraps at N-1 to 0 only on last_fire.
  - frame_cnt wraps silently from 2^CNT_W-1 to 0.

## Timing
- Reset values:
  - state=IDLE, buf_full=0, idx=0, sr=0, buf=0, frame_cnt=0.
  - Outputs: out_valid=0, out_coeff=0, out_idx=0, out_last=0, in_ready=1.
- Reset mid-operation: the active word and the buffered word are discarded immediately (asynchronously). Nothing is emitted after rst_n deasserts until a new in_fire.
- Latency: in_fire in IDLE at cycle t gives out_valid=1 with idx 0 at cycle t+1.
- Throughput: N coefficients per word at 1 per cycle when out_ready=1. Back-to-back words show no idle cycle between the idx N-1 and idx 0 beats.
- in_ready falls the cycle after a word is buffered. It rises the cycle after the last_fire that moves buf into sr.
- frame_cnt updates the cycle after each last_fire.

## Test plan
- Single word in_bits=4'b1010 with out_ready=1:
  - Beats at t+1..t+4 carry coeff 0,9,0,9 and idx 0..3.
  - out_last is high on beat 4 only.
  - Then state returns to IDLE, out_valid=0, frame_cnt=1.
- Streaming 4'b1111, 4'b0000, 4'b0110 with in_valid held high and out_ready=1:
  - 12 contiguous beats: 9,9,9,9, 0,0,0,0, 0,9,9,0.
  - No bubbles; frame_cnt=3.
- Buffer full: send 4'b0001 then 4'b1000 while out_ready=0:
  - in_ready=0 after the second accept; output holds coeff 9, idx 0.
  - Release out_ready: 9,0,0,0 then 0,0,0,9.
  - in_ready=1 the cycle after the first out_last beat.
- Random out_ready backpressure over 200 random words: the coefficient stream matches the reference model exactly, and the outputs are stable whenever out_valid & !out_ready.
- Reset mid-operation: assert rst_n=0 during beat 2 of a word with a second word buffered.
  - Outputs go to their reset values immediately and frame_cnt=0.
  - After release, no beats appear until a new in_fire.
- frame_cnt wrap with CNT_W=2: after 5 words, frame_cnt=1.
